// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: round-robin two-port arbiter and strobe sequencer in front
// of the single-ported data memory (IDLE -> SETUP -> ACCESS -> DONE).
module dmem_access_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 8192,
   parameter int MEM_LAT   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic              p0_err,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic              p1_err,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0]        LAT_M1  = 4'(MEM_LAT - 1);
   localparam logic [ADDR_W-1:0] WORDS_C = ADDR_W'(MEM_WORDS);

   state_t            state_r, state_nxt_s;
   logic [3:0]        cnt_r;
   logic              we_r, grant_r, last_grant_r, err_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r, p0_rdata_r, p1_rdata_r;
   logic              mem_read_r, mem_write_r, p0_ack_r, p1_ack_r, p0_err_r, p1_err_r;
   logic              sel_s, bad_s, rd_nxt_s, wr_nxt_s, ack0_nxt_s, ack1_nxt_s, err_nxt_s, cap_s;

   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      return (a[1:0] != 2'b00) || ((a >> 2'd2) >= WORDS_C);
   endfunction

   assign bad_s = addr_bad(addr_r);

   // Round-robin pick: on a tie the port that was not served last wins
   always_comb begin
      sel_s = 1'b0;
      if (p0_req && p1_req) begin
         sel_s = ~last_grant_r;
      end else if (p1_req) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt_s = IDLE;
      case (state_r)
         IDLE: begin
            if (p0_req || p1_req) state_nxt_s = SETUP;
            else                  state_nxt_s = IDLE;
         end
         SETUP: begin
            if (bad_s) state_nxt_s = DONE;
            else       state_nxt_s = ACCESS;
         end
         ACCESS: begin
            if (cnt_r == 4'd0) state_nxt_s = DONE;
            else               state_nxt_s = ACCESS;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output decode from the next state, so strobes and acks leave flops
   always_comb begin
      rd_nxt_s   = (state_nxt_s == ACCESS) && !we_r;
      wr_nxt_s   = (state_nxt_s == ACCESS) && we_r;
      ack0_nxt_s = (state_nxt_s == DONE) && !grant_r;
      ack1_nxt_s = (state_nxt_s == DONE) && grant_r;
      cap_s      = (state_r == ACCESS) && (cnt_r == 4'd0) && !we_r;
      if (state_r == SETUP) begin
         err_nxt_s = bad_s;
      end else begin
         err_nxt_s = err_r;
      end
   end

   // Request latches, latency counter, round-robin history and read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
         we_r         <= 1'b0;
         addr_r       <= '0;
         wdata_r      <= '0;
         err_r        <= 1'b0;
         cnt_r        <= 4'd0;
         p0_rdata_r   <= '0;
         p1_rdata_r   <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (p0_req || p1_req) begin
                  grant_r <= sel_s;
                  err_r   <= 1'b0;
                  if (sel_s) begin
                     we_r    <= p1_we;
                     addr_r  <= p1_addr;
                     wdata_r <= p1_wdata;
                  end else begin
                     we_r    <= p0_we;
                     addr_r  <= p0_addr;
                     wdata_r <= p0_wdata;
                  end
               end
            end
            SETUP: begin
               err_r <= bad_s;
               cnt_r <= LAT_M1;
            end
            ACCESS: begin
               if (cnt_r != 4'd0) cnt_r <= cnt_r - 4'd1;
            end
            DONE:    last_grant_r <= grant_r;
            default: last_grant_r <= last_grant_r;
         endcase
         if (cap_s) begin
            if (grant_r) p1_rdata_r <= mem_rdata;
            else         p0_rdata_r <= mem_rdata;
         end
      end
   end

   // Registered strobes, acks and error flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         p0_ack_r    <= 1'b0;
         p1_ack_r    <= 1'b0;
         p0_err_r    <= 1'b0;
         p1_err_r    <= 1'b0;
      end else begin
         mem_read_r  <= rd_nxt_s;
         mem_write_r <= wr_nxt_s;
         p0_ack_r    <= ack0_nxt_s;
         p1_ack_r    <= ack1_nxt_s;
         p0_err_r    <= ack0_nxt_s && err_nxt_s;
         p1_err_r    <= ack1_nxt_s && err_nxt_s;
      end
   end

   assign mem_read  = mem_read_r;
   assign mem_write = mem_write_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign p0_ack    = p0_ack_r;
   assign p1_ack    = p1_ack_r;
   assign p0_err    = p0_err_r;
   assign p1_err    = p1_err_r;
   assign p0_rdata  = p0_rdata_r;
   assign p1_rdata  = p1_rdata_r;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequencer and two-port arbiter in front of the single-ported data memory.
- Port 0 is the pipeline load/store unit; port 1 is the debug/program-loader port.
- Serialises requests with round-robin fairness and drives word-addressed read/write strobes with a guaranteed setup phase, so both strobes are never high together and address/data never change while a strobe is high.
- Returns read data and a one-cycle ack per completed transaction; misaligned or out-of-range accesses return an error ack.

Parameters:
- ADDR_W, 32: byte-address width.
- DATA_W, 32: data word width.
- MEM_WORDS, 8192: memory depth in words; word index = addr>>2.
- MEM_LAT, 2: cycles a strobe is held high (ACCESS phase); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request; held high until p0_ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 completion pulse (one cycle).
- p0_err  out  1  port 0 error, valid with p0_ack.
- p0_rdata  out  DATA_W  port 0 read data, valid with p0_ack on a read.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_err, p1_rdata: same as port 0, for port 1.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all acks, errs and strobes 0.
  - mem_addr, mem_wdata, p*_rdata = 0.
  - last_grant=1, so port 0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If any req is high, select a port and latch its we/addr/wdata into internal registers; next state is SETUP.
  - One requester: select it. Both: select the port != last_grant.
  - No req: stay in IDLE.
- SETUP (1 cycle):
  - mem_addr/mem_wdata are driven from the latches; strobes stay 0.
  - If addr[1:0]!=0 or (addr>>2)>=MEM_WORDS: set err, next state DONE (no memory access).
  - Otherwise: next state ACCESS; load cnt=MEM_LAT-1.
- ACCESS:
  - mem_write=we and mem_read=!we, held for exactly MEM_LAT cycles; cnt decrements each cycle.
  - On the last ACCESS cycle (cnt==0), capture mem_rdata into the granted port's rdata register on a read; next state DONE.
- DONE (1 cycle):
  - Strobes are 0.
  - The granted port's ack=1 and err=error flag; the other port's ack stays 0.
  - Update last_grant to the granted port; next state IDLE.
- Latency from the first cycle req is seen high in IDLE:
  - Good access: ack at cycle +MEM_LAT+2.
  - Error: ack at cycle +2.
  - Back-to-back issue restarts from IDLE, so sustained throughput is one transaction per MEM_LAT+3 cycles.
- Requester rules:
  - Inputs are sampled only in IDLE, so later changes to them do not affect an in-flight transaction.
  - Requester must drop req in the cycle after ack; a req still high in the following IDLE is treated as a new request.
- rdata retention:
  - p*_rdata holds its value until that port's next completed read.
  - Writes and errors leave p*_rdata unchanged.
- Invariants:
  - mem_read & mem_write never both 1.
  - mem_addr and mem_wdata are stable while either strobe is high.
  - At most one ack is high per cycle.
- Reset mid-operation: everything returns to the reset values asynchronously. An interrupted write may or may not have reached memory; no ack is ever issued for it.

Test Plan:
- Single write then read, port 0, MEM_LAT=2: write 0x0000_0010 ← 0xDEADBEEF, then read 0x10 → ack 4 cycles after req, rdata=0xDEADBEEF, err=0; mem_write high exactly 2 cycles.
- Simultaneous requests after reset: p0 writes 0x20, p1 writes 0x24 → p0 acked first, p1 acked 5 cycles later; repeat the tie → p0 again first, since last_grant is now 1.
- Fairness under continuous requests: p0 and p1 both always re-request → grants alternate 0,1,0,1 over 8 transactions, and no port is served twice in a row.
- Misaligned address: p1 reads 0x0000_0006 → p1_ack 2 cycles after req with err=1; mem_read never asserts; p1_rdata keeps its previous value.
- Out-of-range address: p0 writes 0x0000_8000 (word 8192) → err=1, mem_write never asserts; a following read of 0x7FFC (word 8191) completes normally.
- Reset mid-ACCESS: assert rst_n=0 during the strobe of a p0 read → strobes, acks and rdata are 0 immediately; after release a new p1 request completes normally.
